// File: rtl/matrix_line_receiver.sv
// Matrix-side receiver for the serial line link: resynchronises sclk/sdata and rebuilds 32-bit row/column words.
// Build macro ONEHOT_CHECK_EN: drop and flag completed words whose row field is not exactly one-hot.
module matrix_line_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_in,
  input  logic        sdata_in,
  input  logic        err_clr,
  output logic [15:0] row_out,
  output logic [15:0] col_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic [4:0]  bit_cnt
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_reg, sclk_sync_next;
  logic [SYNC_STAGES-1:0] sdata_sync_reg, sdata_sync_next;
  logic                   sclk_prev_reg;
  logic [30:0]            shift_reg;
  logic [4:0]             bit_cnt_reg;
  logic [IW-1:0]          idle_cnt_reg;
  logic [15:0]            row_reg, col_reg;
  logic                   word_valid_reg, frame_err_reg;

  logic        sclk_s, sdata_s, fall, word_done, word_ok, timeout_fire, err_set;
  logic [31:0] word_full;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign sclk_sync_next[gi]  = sclk_in;
        assign sdata_sync_next[gi] = sdata_in;
      end else begin : g_tail
        assign sclk_sync_next[gi]  = sclk_sync_reg[gi-1];
        assign sdata_sync_next[gi] = sdata_sync_reg[gi-1];
      end
    end
  endgenerate

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync_reg[SYNC_STAGES-1];
  assign fall      = sclk_prev_reg & ~sclk_s;
  // Bit 31 is never stored: it completes the word straight from the synchroniser.
  assign word_full = {sdata_s, shift_reg};
  assign word_done = fall && (bit_cnt_reg == 5'd31);

`ifdef ONEHOT_CHECK_EN
  logic [15:0] row_field;
  assign row_field = word_full[31:16];
  assign word_ok   = (row_field != 16'd0) && ((row_field & (row_field - 16'd1)) == 16'd0);
`else
  assign word_ok   = 1'b1;
`endif

  // A fall always restarts the idle count, so it can never coincide with a discard.
  assign timeout_fire = !fall && (idle_cnt_reg == IDLE_LAST) && (bit_cnt_reg != 5'd0);
  assign err_set      = timeout_fire || (word_done && !word_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg  <= '0;
      sdata_sync_reg <= '0;
      sclk_prev_reg  <= 1'b0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      idle_cnt_reg   <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      word_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sclk_sync_reg  <= sclk_sync_next;
      sdata_sync_reg <= sdata_sync_next;
      sclk_prev_reg  <= sclk_s;
      if (fall) begin
        if (bit_cnt_reg != 5'd31)
          shift_reg[bit_cnt_reg] <= sdata_s;
        bit_cnt_reg  <= bit_cnt_reg + 5'd1;
        idle_cnt_reg <= '0;
      end else begin
        if (idle_cnt_reg != IDLE_MAX)
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        if (timeout_fire)
          bit_cnt_reg <= '0;
      end
      word_valid_reg <= word_done && word_ok;
      if (word_done && word_ok) begin
        row_reg <= word_full[31:16];
        col_reg <= word_full[15:0];
      end
      if (err_set)
        frame_err_reg <= 1'b1;
      else if (err_clr)
        frame_err_reg <= 1'b0;
    end
  end

  assign row_out    = row_reg;
  assign col_out    = col_reg;
  assign word_valid = word_valid_reg;
  assign frame_err  = frame_err_reg;
  assign bit_cnt    = bit_cnt_reg;

endmodule
